// File: rtl/smvm_row_accumulator.sv
// rtl/smvm_row_accumulator.sv - multi-lane sparse matrix-vector row accumulator
module smvm_row_accumulator #(
  parameter int NUM_CHANNELS = 4,
  parameter int MATRIX_SIZE  = 128,
  parameter int VEC_SIZE     = 1024,
  parameter int DATA_W       = 32,
  parameter int ACC_W        = 32,
  parameter int VEC_LAT      = 1,
  localparam int CW = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1,
  localparam int RW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CHANNELS*DATA_W-1:0] in_value,
  input  logic [NUM_CHANNELS*32-1:0]     in_col_id,
  input  logic [NUM_CHANNELS*32-1:0]     in_row_id,
  output logic                           vec_rd,
  output logic [NUM_CHANNELS*CW-1:0]     vec_addr,
  input  logic [NUM_CHANNELS*DATA_W-1:0] vec_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [RW-1:0]                  out_row,
  output logic [ACC_W-1:0]               out_data,
  output logic                           done
);
  localparam int NC = NUM_CHANNELS;
  localparam int FLW = $clog2(VEC_LAT + 2) + 1;
  localparam logic [FLW-1:0] FL_LAST = FLW'(VEC_LAT + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MATRIX_SIZE - 1);
  localparam logic [31:0] MS32 = 32'(MATRIX_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_OUT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [NC-1:0]     fin_q, fin_d;
  logic [RW-1:0]     cnt_q, cnt_d;
  logic [FLW-1:0]    fl_q, fl_d;
  logic              clear_acc;
  logic              accept;
  logic [NC-1:0]     lane_sent;
  logic [NC-1:0]     act_in;
  logic [NC*RW-1:0]  row_in;

  logic [NC-1:0]        dact_q [VEC_LAT];
  logic [NC*DATA_W-1:0] dval_q [VEC_LAT];
  logic [NC*RW-1:0]     drow_q [VEC_LAT];

  logic [NC-1:0]              mact_q;
  logic signed [2*DATA_W-1:0] mprod_q [NC];
  logic [RW-1:0]              mrow_q [NC];

  logic [NC-1:0]    lead;
  logic [ACC_W-1:0] lane_sum [NC];
  logic [ACC_W-1:0] acc_q [MATRIX_SIZE];
  logic             unused_bits;

  assign in_ready  = (state_q == S_RUN);
  assign accept    = in_valid & in_ready;
  assign vec_rd    = accept;
  assign out_valid = (state_q == S_OUT);
  assign done      = (state_q == S_DONE);
  assign out_row   = cnt_q;
  assign out_data  = out_valid ? acc_q[cnt_q] : '0;

  // Per-lane decode: sentinel detection, active mask, row index and read address.
  always_comb begin
    lane_sent   = '0;
    act_in      = '0;
    row_in      = '0;
    vec_addr    = '0;
    unused_bits = 1'b0;
    for (int k = 0; k < NC; k++) begin
      lane_sent[k] = (in_row_id[k*32 +: 32] >= MS32);
      act_in[k]    = accept & ~fin_q[k] & ~lane_sent[k];
      row_in[k*RW +: RW] = in_row_id[k*32 +: RW];
      if (accept) vec_addr[k*CW +: CW] = in_col_id[k*32 +: CW];
      unused_bits = unused_bits ^ (^in_col_id[k*32 +: 32]) ^ (^mprod_q[k]);
    end
  end

  // Next-state logic for the run / flush / unload sequence.
  always_comb begin
    state_d   = state_q;
    fin_d     = fin_q;
    cnt_d     = cnt_q;
    fl_d      = fl_q;
    clear_acc = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clear_acc = 1'b1;
          fin_d     = '0;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          fin_d = fin_q | lane_sent;
          if (&fin_d) begin
            state_d = S_FLUSH;
            fl_d    = '0;
          end
        end
      end
      S_FLUSH: begin
        if (fl_q == FL_LAST) state_d = S_OUT;
        else                 fl_d    = fl_q + FLW'(1);
      end
      S_OUT: begin
        if (out_ready) begin
          cnt_d = cnt_q + RW'(1);
          if (cnt_q == ROW_LAST) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      fin_q   <= '0;
      cnt_q   <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      fin_q   <= fin_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
    end
  end

  // Delay line aligning mask, values and rows with the returning vector data.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < VEC_LAT; i++) dact_q[i] <= '0;
    end else begin
      dact_q[0] <= act_in;
      dval_q[0] <= in_value;
      drow_q[0] <= row_in;
      for (int i = 1; i < VEC_LAT; i++) begin
        dact_q[i] <= dact_q[i-1];
        dval_q[i] <= dval_q[i-1];
        drow_q[i] <= drow_q[i-1];
      end
    end
  end

  // Multiply stage: full-width signed product per lane.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      mact_q <= '0;
    end else begin
      mact_q <= dact_q[VEC_LAT-1];
      for (int k = 0; k < NC; k++) begin
        mprod_q[k] <= $signed(dval_q[VEC_LAT-1][k*DATA_W +: DATA_W]) *
                      $signed(vec_data[k*DATA_W +: DATA_W]);
        mrow_q[k]  <= drow_q[VEC_LAT-1][k*RW +: RW];
      end
    end
  end

  // Combine lanes sharing a row; the lowest such lane is the one that writes.
  always_comb begin
    lead = mact_q;
    for (int k = 0; k < NC; k++) begin
      lane_sum[k] = '0;
      for (int j = 0; j < NC; j++) begin
        if (mact_q[j] && (mrow_q[j] == mrow_q[k])) begin
          lane_sum[k] = lane_sum[k] + mprod_q[j][ACC_W-1:0];
          if (j < k) lead[k] = 1'b0;
        end
      end
    end
  end

  // Row accumulators: single-cycle read-modify-write, wrapping arithmetic.
  always_ff @(posedge clk) begin
    if (!rst_l || clear_acc) begin
      for (int r = 0; r < MATRIX_SIZE; r++) acc_q[r] <= '0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (lead[k]) acc_q[mrow_q[k]] <= acc_q[mrow_q[k]] + lane_sum[k];
      end
    end
  end
endmodule

// File: tb/tb_smvm_row_accumulator.sv
// tb/tb_smvm_row_accumulator.sv - scoreboard bench for smvm_row_accumulator
module tb_smvm_row_accumulator;
  localparam int NC = 4, MS = 128, DW = 32, AW = 32, CW = 10, RW = 7;

  typedef logic [3:0][31:0] lanes_t;
  typedef struct {
    lanes_t      r;
    lanes_t      c;
    lanes_t      v;
    int          er;
    logic [31:0] ev;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_l, start, in_valid, out_ready;
  logic [NC*DW-1:0] in_value;
  logic [NC*32-1:0] in_col_id, in_row_id;

  logic in_ready_a, vec_rd_a, out_valid_a, done_a;
  logic [NC*CW-1:0] vec_addr_a;
  logic [NC*DW-1:0] vec_data_a;
  logic [RW-1:0] out_row_a;
  logic [AW-1:0] out_data_a;

  logic in_ready_b, vec_rd_b, out_valid_b, done_b;
  logic [NC*CW-1:0] vec_addr_b;
  logic [NC*DW-1:0] vec_data_b;
  logic [RW-1:0] out_row_b;
  logic [AW-1:0] out_data_b;

  smvm_row_accumulator #(.VEC_LAT(1)) dut_a (
    .clk(clk), .rst_l(rst_l), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_value(in_value), .in_col_id(in_col_id), .in_row_id(in_row_id),
    .vec_rd(vec_rd_a), .vec_addr(vec_addr_a), .vec_data(vec_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_row(out_row_a),
    .out_data(out_data_a), .done(done_a));

  smvm_row_accumulator #(.VEC_LAT(3)) dut_b (
    .clk(clk), .rst_l(rst_l), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_value(in_value), .in_col_id(in_col_id), .in_row_id(in_row_id),
    .vec_rd(vec_rd_b), .vec_addr(vec_addr_b), .vec_data(vec_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_row(out_row_b),
    .out_data(out_data_b), .done(done_b));

  // Vector memory: x[c] = c + 1, latency 1 for dut_a and 3 for dut_b.
  function automatic logic [NC*DW-1:0] xfetch(input logic [NC*CW-1:0] a);
    logic [NC*DW-1:0] d;
    for (int k = 0; k < NC; k++) d[k*DW +: DW] = 32'(a[k*CW +: CW]) + 32'd1;
    return d;
  endfunction

  logic [NC*DW-1:0] vb1, vb2;
  always @(posedge clk) begin
    vec_data_a <= xfetch(vec_addr_a);
    vb1        <= xfetch(vec_addr_b);
    vb2        <= vb1;
    vec_data_b <= vb2;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  logic [31:0] acc_m [MS];
  bit          fin_m [NC];
  int          t_last;
  logic [RW+AW-1:0] sbq0 [$];
  logic [RW+AW-1:0] sbq1 [$];

  bit          mon_en;
  bit          first_seen [2];
  bit          prev_stall [2];
  bit          pend_done [2];
  logic [RW-1:0] prev_row [2];
  logic [AW-1:0] prev_data [2];
  int          rx_cnt [2];
  logic [AW-1:0] cap [2][MS];

  bit       bp;
  logic [3:0] pat = 4'b1001;

  initial begin
    int k;
    k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp ? pat[k % 4] : 1'b1;
      k++;
    end
  end

  task automatic mon(input int id, input int lat, input logic ov, input logic dn,
                     input logic [RW-1:0] row, input logic [AW-1:0] data);
    logic [RW+AW-1:0] e;
    bit empty;
    if (pend_done[id]) begin
      chk($sformatf("done_next%0d", id), dn, 1);
      pend_done[id] = 0;
    end
    if (ov) begin
      if (!first_seen[id]) begin
        chk($sformatf("flush_lat%0d", id), cyc - t_last, lat + 3);
        first_seen[id] = 1;
      end
      if (prev_stall[id]) begin
        chk($sformatf("stall_row%0d", id), row, prev_row[id]);
        chk($sformatf("stall_data%0d", id), data, prev_data[id]);
      end
      if (out_ready) begin
        empty = (id == 0) ? (sbq0.size() == 0) : (sbq1.size() == 0);
        if (empty) begin
          chk($sformatf("sb_unexpected%0d", id), 1, 0);
        end else begin
          e = (id == 0) ? sbq0.pop_front() : sbq1.pop_front();
          chk($sformatf("out_row%0d", id), row, e[RW+AW-1:AW]);
          chk($sformatf("out_data%0d_r%0d", id, row), data, e[AW-1:0]);
        end
        cap[id][row] = data;
        rx_cnt[id]++;
        if (row == RW'(MS - 1)) pend_done[id] = 1;
        prev_stall[id] = 0;
      end else begin
        prev_stall[id] = 1;
        prev_row[id]   = row;
        prev_data[id]  = data;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_l) begin
      mon(0, 1, out_valid_a, done_a, out_row_a, out_data_a);
      mon(1, 3, out_valid_b, done_b, out_row_b, out_data_b);
    end
  end

  function automatic lanes_t mk(input logic [31:0] a0, a1, a2, a3);
    lanes_t l;
    l[0] = a0; l[1] = a1; l[2] = a2; l[3] = a3;
    return l;
  endfunction

  task automatic check_reset();
    chk("rst_in_ready_a", in_ready_a, 0);   chk("rst_in_ready_b", in_ready_b, 0);
    chk("rst_vec_rd_a", vec_rd_a, 0);       chk("rst_vec_rd_b", vec_rd_b, 0);
    chk("rst_vec_addr_a", vec_addr_a, 0);   chk("rst_vec_addr_b", vec_addr_b, 0);
    chk("rst_out_valid_a", out_valid_a, 0); chk("rst_out_valid_b", out_valid_b, 0);
    chk("rst_out_row_a", out_row_a, 0);     chk("rst_out_row_b", out_row_b, 0);
    chk("rst_out_data_a", out_data_a, 0);   chk("rst_out_data_b", out_data_b, 0);
    chk("rst_done_a", done_a, 0);           chk("rst_done_b", done_b, 0);
  endtask

  task automatic drive_beat(input lanes_t r, input lanes_t c, input lanes_t v);
    bit ok;
    int n;
    int ta;
    bit all;
    logic [NC*CW-1:0] ea;
    longint p;
    for (int k = 0; k < NC; k++) ea[k*CW +: CW] = c[k][CW-1:0];
    in_valid = 1'b1; in_row_id = r; in_col_id = c; in_value = v;
    ok = 0; n = 0; ta = 0;
    do begin
      @(negedge clk);
      ok = in_ready_a;
      if (ok) begin
        ta = cyc;
        chk("vec_rd", vec_rd_a, 1);
        chk("vec_addr_a", vec_addr_a, ea);
        chk("vec_addr_b", vec_addr_b, ea);
        chk("in_ready_b", in_ready_b, 1);
      end
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    in_valid = 1'b0;
    if (!ok) begin
      chk("beat_accept_timeout", 0, 1);
    end else begin
      all = 1;
      for (int k = 0; k < NC; k++) begin
        if (!fin_m[k]) begin
          if (r[k] >= 32'(MS)) begin
            fin_m[k] = 1;
          end else begin
            p = longint'($signed(v[k])) * (longint'(c[k][CW-1:0]) + 1);
            acc_m[r[k][RW-1:0]] = acc_m[r[k][RW-1:0]] + p[31:0];
          end
        end
        all = all & fin_m[k];
      end
      if (all) t_last = ta;
    end
  endtask

  task automatic start_run(input bit with_beat);
    for (int r = 0; r < MS; r++) begin
      acc_m[r] = '0;
      cap[0][r] = 32'hDEADBEEF;
      cap[1][r] = 32'hDEADBEEF;
    end
    for (int k = 0; k < NC; k++) fin_m[k] = 0;
    for (int i = 0; i < 2; i++) begin
      first_seen[i] = 0; prev_stall[i] = 0; pend_done[i] = 0; rx_cnt[i] = 0;
    end
    sbq0.delete();
    sbq1.delete();
    mon_en = 1;
    start = 1'b1;
    if (with_beat) begin
      in_valid = 1'b1;
      in_row_id = mk(50, 50, 50, 50);
      in_col_id = mk(0, 0, 0, 0);
      in_value  = mk(77, 77, 77, 77);
    end
    @(negedge clk);
    if (with_beat) chk("start_beat_ready", in_ready_a, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic finish_run();
    int n;
    for (int r = 0; r < MS; r++) begin
      sbq0.push_back({7'(r), acc_m[r]});
      sbq1.push_back({7'(r), acc_m[r]});
    end
    @(negedge clk);
    chk("flush_ready_a", in_ready_a, 0);
    chk("flush_ready_b", in_ready_b, 0);
    n = 0;
    while (!(done_a && done_b) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done_a && done_b, 1);
    chk("rx_cnt_a", rx_cnt[0], MS);
    chk("rx_cnt_b", rx_cnt[1], MS);
    chk("done_out_valid_a", out_valid_a, 0);
    chk("done_out_valid_b", out_valid_b, 0);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [4];
  lanes_t sent;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{mk(0, 1, 2, 3), mk(0, 1, 2, 3), mk(2, 3, 4, 5), 3, 32'd20};
    tbl[1] = '{mk(7, 7, 7, 7), mk(0, 1, 2, 3), mk(1, 1, 1, 1), 7, 32'd10};
    tbl[2] = '{mk(0, 200, 200, 200), mk(0, 0, 0, 0), mk(32'hFFFFFFFF, 0, 0, 0), 0, 32'hFFFFFFFF};
    tbl[3] = '{mk(10, 10, 127, 11), mk(5, 6, 1023, 100),
               mk(32'hFFFFFFFD, 7, 2, 32'h7FFFFFFF), 11, 32'h7FFFFF9B};
    sent = mk(200, 200, 200, 200);

    rst_l = 1'b0; start = 1'b0; in_valid = 1'b0; bp = 0; mon_en = 0;
    in_value = '0; in_col_id = '0; in_row_id = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_l = 1'b1;
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      start_run(i == 0);
      drive_beat(tbl[i].r, tbl[i].c, tbl[i].v);
      drive_beat(sent, mk(0, 0, 0, 0), mk(0, 0, 0, 0));
      finish_run();
      chk($sformatf("tbl%0d_a", i), cap[0][tbl[i].er], tbl[i].ev);
      chk($sformatf("tbl%0d_b", i), cap[1][tbl[i].er], tbl[i].ev);
      if (i == 0) chk("start_beat_ignored", cap[0][50], 0);
      if (i == 3) chk("tbl3_row127", cap[0][127], 2048);
    end

    start_run(0);
    repeat (8) drive_beat(mk(5, 5, 5, 5), mk(0, 0, 0, 0), mk(1, 1, 1, 1));
    drive_beat(sent, mk(0, 0, 0, 0), mk(0, 0, 0, 0));
    finish_run();
    chk("b2b_row5_a", cap[0][5], 32);
    chk("b2b_row5_b", cap[1][5], 32);

    start_run(0);
    drive_beat(mk(200, 1, 2, 3), mk(0, 0, 0, 0), mk(5, 1, 1, 1));
    drive_beat(mk(9, 4, 4, 4), mk(0, 1, 2, 3), mk(100, 1, 1, 1));
    @(negedge clk);
    chk("stag_still_run", in_ready_a, 1);
    @(posedge clk);
    #1;
    drive_beat(mk(9, 200, 200, 200), mk(0, 0, 0, 0), mk(100, 0, 0, 0));
    finish_run();
    chk("stag_row9_a", cap[0][9], 0);
    chk("stag_row9_b", cap[1][9], 0);
    chk("stag_row4", cap[0][4], 9);

    bp = 1;
    start_run(0);
    drive_beat(tbl[2].r, tbl[2].c, tbl[2].v);
    drive_beat(sent, mk(0, 0, 0, 0), mk(0, 0, 0, 0));
    finish_run();
    bp = 0;
    chk("bp_wrap_a", cap[0][0], 32'hFFFFFFFF);
    chk("bp_wrap_b", cap[1][0], 32'hFFFFFFFF);

    start_run(0);
    drive_beat(mk(0, 1, 2, 3), mk(0, 0, 0, 0), mk(9, 9, 9, 9));
    mon_en = 0;
    rst_l = 1'b0;
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1;
    start_run(0);
    drive_beat(tbl[0].r, tbl[0].c, tbl[0].v);
    drive_beat(sent, mk(0, 0, 0, 0), mk(0, 0, 0, 0));
    finish_run();
    chk("post_rst_row0_a", cap[0][0], 2);
    chk("post_rst_row1_b", cap[1][1], 6);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
